serial_frame_tx: RTL and testbench

Parallel-load serial frame transmitter. Accepts a WIDTH-bit word on a one-cycle load strobe and shifts it out on a single line as start bit (0), data LSB first, optional even-parity bit, then stop bit (1). One bit is sent per clock. It is the sending end of the lab serial link, and drives a single-bit line to a matching receiver built from the team's flip-flop library.

---
 rtl/serial_frame_tx.sv | 123 ++++++++++++
 tb/tb_serial_frame_tx.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/serial_frame_tx.sv
// Parallel-load serial frame transmitter: start bit, WIDTH data bits LSB first,
// optional even parity, stop bit. One bit per falling edge of C.
module serial_frame_tx #(
    parameter int unsigned WIDTH     = 8,
    parameter int unsigned PARITY_EN = 0
) (
    input  logic             C,
    input  logic             RE,
    input  logic [WIDTH-1:0] D,
    input  logic             LD,
    output logic             TX,
    output logic             BUSY,
    output logic             DONE
);

    localparam int unsigned   CW      = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LastCnt = CW'(WIDTH - 1);

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
        StParity,
        StStop
    } state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] shift_q, shift_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             par_q, par_d;
    logic             tx_q, tx_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             load;

    // A load is accepted when idle or on the edge that leaves the stop bit.
    assign load = LD && (state_q == StIdle || state_q == StStop);

    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        cnt_d   = cnt_q;
        par_d   = par_q;
        tx_d    = tx_q;
        busy_d  = busy_q;
        done_d  = 1'b0;

        unique case (state_q)
            StIdle: begin
                tx_d   = 1'b1;
                busy_d = 1'b0;
            end
            StStart: begin
                state_d = StData;
                tx_d    = shift_q[0];
            end
            StData: begin
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == LastCnt) begin
                    if (PARITY_EN != 0) begin
                        state_d = StParity;
                        tx_d    = par_q;
                    end else begin
                        state_d = StStop;
                        tx_d    = 1'b1;
                    end
                end else begin
                    shift_d = shift_q >> 1;
                    tx_d    = shift_q[1];
                end
            end
            StParity: begin
                state_d = StStop;
                tx_d    = 1'b1;
            end
            StStop: begin
                done_d  = 1'b1;
                state_d = StIdle;
                tx_d    = 1'b1;
                busy_d  = 1'b0;
            end
            default: begin
                state_d = StIdle;
                tx_d    = 1'b1;
                busy_d  = 1'b0;
            end
        endcase

        if (load) begin
            state_d = StStart;
            shift_d = D;
            cnt_d   = '0;
            par_d   = ^D;
            tx_d    = 1'b0;
            busy_d  = 1'b1;
        end
    end

    always_ff @(negedge C) begin
        if (RE) begin
            state_q <= StIdle;
            shift_q <= '0;
            cnt_q   <= '0;
            par_q   <= 1'b0;
            tx_q    <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            cnt_q   <= cnt_d;
            par_q   <= par_d;
            tx_q    <= tx_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign TX   = tx_q;
    assign BUSY = busy_q;
    assign DONE = done_q;

endmodule

// File: tb/tb_serial_frame_tx.sv
// Self-checking bench for serial_frame_tx: one instance without parity, one with.
module tb_serial_frame_tx;

    localparam int W = 8;

    logic         C;
    logic         re   [2];
    logic         ld   [2];
    logic [W-1:0] d    [2];
    logic         tx   [2];
    logic         busy [2];
    logic         done [2];

    int total = 0;
    int bad   = 0;

    serial_frame_tx #(.WIDTH(W), .PARITY_EN(0)) u_p0 (
        .C(C), .RE(re[0]), .D(d[0]), .LD(ld[0]), .TX(tx[0]), .BUSY(busy[0]), .DONE(done[0])
    );

    serial_frame_tx #(.WIDTH(W), .PARITY_EN(1)) u_p1 (
        .C(C), .RE(re[1]), .D(d[1]), .LD(ld[1]), .TX(tx[1]), .BUSY(busy[1]), .DONE(done[1])
    );

    initial C = 1'b1;
    always #5 C = ~C;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    // Instance k==1 carries the parity bit.
    function automatic int frame_len(int k);
        return W + 2 + k;
    endfunction

    // Expected line value c cycles after the load edge.
    function automatic logic exp_bit(int k, logic [W-1:0] data, int c);
        if (c == 0) return 1'b0;
        if (c <= W) return data[c-1];
        if (k == 1 && c == W + 1) return logic'($countones(data) % 2);
        return 1'b1;
    endfunction

    task automatic tick();
        @(negedge C);
        #1;
    endtask

    task automatic check(string tag, logic obs, logic exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic check_idle(int k, string tag);
        check($sformatf("%s u%0d tx", tag, k), tx[k], 1'b1);
        check($sformatf("%s u%0d busy", tag, k), busy[k], 1'b0);
        check($sformatf("%s u%0d done", tag, k), done[k], 1'b0);
    endtask

    task automatic load(int k, logic [W-1:0] data);
        ld[k] = 1'b1;
        d[k]  = data;
        tick();
        ld[k] = 1'b0;
        d[k]  = W'($urandom);
    endtask

    // Checks a frame starting at its load edge; optional ignored LD at cycle junk,
    // optional chained load of nxt at the edge leaving the stop bit.
    task automatic body(int k, logic [W-1:0] data, logic first_done, int junk, bit chain,
                        logic [W-1:0] nxt);
        int len;
        len = frame_len(k);
        for (int c = 0; c < len; c++) begin
            check($sformatf("u%0d d=%h c%0d tx", k, data, c), tx[k], exp_bit(k, data, c));
            check($sformatf("u%0d d=%h c%0d busy", k, data, c), busy[k], 1'b1);
            check($sformatf("u%0d d=%h c%0d done", k, data, c), done[k],
                  (c == 0) ? first_done : 1'b0);
            ld[k] = 1'b0;
            if (c == junk) begin
                ld[k] = 1'b1;
                d[k]  = '0;
            end
            if (chain && c == len - 1) begin
                ld[k] = 1'b1;
                d[k]  = nxt;
            end
            tick();
        end
        check($sformatf("u%0d d=%h end done", k, data), done[k], 1'b1);
        check($sformatf("u%0d d=%h end busy", k, data), busy[k], chain);
        check($sformatf("u%0d d=%h end tx", k, data), tx[k], !chain);
        if (!chain) begin
            ld[k] = 1'b0;
            tick();
            check_idle(k, $sformatf("d=%h after", data));
        end
    endtask

    initial begin
        logic [W-1:0] data;
        logic [W-1:0] nxt;
        int           k;
        int           junk;
        bit           chain;

        // Reset holds off a pending load
        for (int i = 0; i < 2; i++) begin
            re[i] = 1'b1;
            ld[i] = 1'b1;
            d[i]  = 8'hFF;
        end
        tick();
        check_idle(0, "reset1");
        check_idle(1, "reset1");
        tick();
        check_idle(0, "reset2");
        check_idle(1, "reset2");
        for (int i = 0; i < 2; i++) begin
            re[i] = 1'b0;
            ld[i] = 1'b0;
        end
        tick();
        check_idle(0, "post_reset");
        check_idle(1, "post_reset");

        // Directed frames
        load(0, 8'hA5);
        body(0, 8'hA5, 1'b0, -1, 1'b0, '0);
        load(1, 8'h07);
        body(1, 8'h07, 1'b0, -1, 1'b0, '0);
        load(1, 8'h03);
        body(1, 8'h03, 1'b0, -1, 1'b0, '0);

        // Load during third data cycle is ignored
        load(0, 8'hA5);
        body(0, 8'hA5, 1'b0, 3, 1'b0, '0);

        // Back-to-back
        load(0, 8'h01);
        body(0, 8'h01, 1'b0, -1, 1'b1, 8'h80);
        body(0, 8'h80, 1'b1, -1, 1'b0, '0);

        // Reset during the fifth data bit
        load(0, 8'hC3);
        for (int c = 0; c <= 5; c++) begin
            check($sformatf("abort c%0d tx", c), tx[0], exp_bit(0, 8'hC3, c));
            check($sformatf("abort c%0d busy", c), busy[0], 1'b1);
            if (c < 5) tick();
        end
        re[0] = 1'b1;
        tick();
        check_idle(0, "abort_edge");
        re[0] = 1'b0;
        tick();
        check_idle(0, "abort_after");
        load(0, 8'h5A);
        body(0, 8'h5A, 1'b0, -1, 1'b0, '0);

        // Randomized frames
        for (int n = 0; n < 24; n++) begin
            k     = int'($urandom_range(0, 1));
            data  = W'($urandom);
            nxt   = W'($urandom);
            junk  = ($urandom_range(0, 1) == 1) ?
                    int'($urandom_range(0, frame_len(k) - 2)) : -1;
            chain = bit'($urandom_range(0, 1));
            load(k, data);
            body(k, data, 1'b0, junk, chain, nxt);
            if (chain) body(k, nxt, 1'b1, -1, 1'b0, '0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
